// File: rtl/fos_out_conditioner.sv
// Output conditioning after the FOS filter: round, shift and clamp the 32-bit
// result, then buffer it in a small FIFO with saturation/drop diagnostics.
module fos_out_conditioner #(
  parameter int SHIFT = 10,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      sat_count,
  output logic [15:0]      drop_count,
  output logic             overflow,
  input  logic             clear_flags
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  localparam logic signed [32:0] ROUND_C = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] MAX_C   = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MIN_C   = -(33'sd1 <<< (OUT_W - 1));

  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ZERO   = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE    = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W+1)'(DEPTH);
  localparam logic [15:0]      CNT16_MAX  = 16'hFFFF;
  localparam logic [15:0]      CNT16_ZERO = 16'h0000;
  localparam logic [OUT_W-1:0] DATA_ZERO  = {OUT_W{1'b0}};

  logic signed [32:0] ext_s;
  logic signed [32:0] sum_s;
  logic signed [32:0] shr_s;
  logic [OUT_W-1:0]   clamp_s;
  logic               clamp_sat_s;

  logic               s_valid_r;
  logic               s_sat_r;
  logic [OUT_W-1:0]   s_data_r;

  logic [OUT_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W:0]     count_r;

  logic [15:0]        sat_count_r;
  logic [15:0]        drop_count_r;
  logic               overflow_r;

  logic               out_valid_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;

  // Round-half-up and arithmetic shift on a 33-bit copy, then clamp to OUT_W.
  always_comb begin
    ext_s = {in_data[31], in_data};
    sum_s = ext_s + ROUND_C;
    shr_s = sum_s >>> SHIFT;
    if (shr_s > MAX_C) begin
      clamp_s     = MAX_C[OUT_W-1:0];
      clamp_sat_s = 1'b1;
    end else if (shr_s < MIN_C) begin
      clamp_s     = MIN_C[OUT_W-1:0];
      clamp_sat_s = 1'b1;
    end else begin
      clamp_s     = shr_s[OUT_W-1:0];
      clamp_sat_s = 1'b0;
    end
  end

  // Stage-1 scale register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid_r <= 1'b0;
      s_sat_r   <= 1'b0;
      s_data_r  <= DATA_ZERO;
    end else begin
      s_valid_r <= in_valid;
      s_sat_r   <= clamp_sat_s;
      s_data_r  <= clamp_s;
    end
  end

  // Handshake qualification; a full FIFO still takes a push when it pops.
  always_comb begin
    out_valid_s = (count_r != CNT_ZERO);
    pop_s       = out_valid_s && out_ready;
    if (s_valid_r && ((count_r < DEPTH_C) || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    drop_s = s_valid_r && !push_s;
  end

  // FIFO storage and pointers; storage is cleared so out_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= s_data_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Diagnostic counters; clear_flags wins over an event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clear_flags) begin
      sat_count_r  <= CNT16_ZERO;
      drop_count_r <= CNT16_ZERO;
      overflow_r   <= 1'b0;
    end else begin
      if (s_valid_r && s_sat_r && (sat_count_r != CNT16_MAX)) begin
        sat_count_r <= sat_count_r + 16'd1;
      end else begin
        sat_count_r <= sat_count_r;
      end
      if (drop_s && (drop_count_r != CNT16_MAX)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end else begin
        drop_count_r <= drop_count_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign out_valid  = out_valid_s;
  assign out_data   = mem_r[rd_ptr_r];
  assign sat_count  = sat_count_r;
  assign drop_count = drop_count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_fos_out_conditioner.sv
// Scoreboard bench for fos_out_conditioner: a cycle model predicts FIFO
// contents and diagnostics; outputs are compared 1 ns after each rising edge.
module tb_fos_out_conditioner;

  localparam int SHIFT = 10;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [31:0]      in_data;
  logic             in_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      sat_count;
  logic [15:0]      drop_count;
  logic             overflow;
  logic             clear_flags;

  fos_out_conditioner #(.SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_count(sat_count), .drop_count(drop_count), .overflow(overflow),
    .clear_flags(clear_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [OUT_W-1:0] exp_q[$];
  logic             m_sv = 1'b0;
  logic             m_ss = 1'b0;
  logic [OUT_W-1:0] m_sval = '0;
  int               m_sc = 0;
  int               m_dc = 0;
  logic             m_ov = 1'b0;
  logic             after_rst = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference scaling: floor((x + 2^(S-1)) / 2^S) with explicit floor, then clamp.
  function automatic void scale(input logic [31:0] d, output logic [OUT_W-1:0] v, output logic sat);
    longint x   = longint'($signed(d));
    longint den = longint'(1) << SHIFT;
    longint r   = x + (den / 2);
    longint qt  = r / den;
    longint hi  = (longint'(1) << (OUT_W - 1)) - 1;
    longint lo  = -(longint'(1) << (OUT_W - 1));
    if (r < 0 && (r % den) != 0) qt = qt - 1;
    sat = 1'b0;
    if (qt > hi) begin qt = hi; sat = 1'b1; end
    else if (qt < lo) begin qt = lo; sat = 1'b1; end
    v = qt[OUT_W-1:0];
  endfunction

  task automatic model_step();
    bit pop, push;
    logic [OUT_W-1:0] v;
    logic s;
    if (reset) begin
      exp_q.delete();
      m_sv = 1'b0; m_ss = 1'b0; m_sc = 0; m_dc = 0; m_ov = 1'b0;
      after_rst = 1'b1;
    end else begin
      pop  = (exp_q.size() != 0) && out_ready;
      push = m_sv && ((exp_q.size() < DEPTH) || pop);
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(m_sval);
        after_rst = 1'b0;
      end
      if (clear_flags) begin
        m_sc = 0; m_dc = 0; m_ov = 1'b0;
      end else begin
        if (m_sv && m_ss && m_sc < 16'hFFFF) m_sc++;
        if (m_sv && !push) begin
          if (m_dc < 16'hFFFF) m_dc++;
          m_ov = 1'b1;
        end
      end
      scale(in_data, v, s);
      m_sv = in_valid; m_sval = v; m_ss = s;
    end
  endtask

  task automatic compare();
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("out_data", {16'd0, out_data}, {16'd0, exp_q[0]});
    else if (after_rst) check("out_data_empty", {16'd0, out_data}, 32'd0);
    check("sat_count", {16'd0, sat_count}, m_sc);
    check("drop_count", {16'd0, drop_count}, m_dc);
    check("overflow", {31'd0, overflow}, {31'd0, m_ov});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_data = 32'd0; in_valid = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    idle(1);

    // Basic rounding and 2-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0C00);
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 32'h0000_0600);
    check("first_out", {16'd0, out_data}, 32'h0000_0003);
    drive(1'b0, 32'd0);
    check("second_out", {16'd0, out_data}, 32'h0000_0002);
    idle(2);

    // Negative rounding
    drive(1'b1, 32'hFFFF_FA00);
    drive(1'b1, 32'hFFFF_F800);
    idle(3);

    // Saturation both ways, then clear
    drive(1'b1, 32'h7FFF_FFFF);
    drive(1'b1, 32'h8000_0000);
    idle(3);
    check("sat_two", {16'd0, sat_count}, 32'd2);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    check("sat_cleared", {16'd0, sat_count}, 32'd0);

    // Overfill with the consumer stalled, then drain
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) drive(1'b1, 32'(k) << SHIFT);
    idle(2);
    check("drop_two", {16'd0, drop_count}, 32'd2);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("head_one", {16'd0, out_data}, 32'd1);
    out_ready = 1'b1;
    idle(6);

    // Full FIFO: push alongside pop must be accepted
    out_ready = 1'b0;
    for (int k = 10; k < 14; k++) drive(1'b1, 32'(k) << SHIFT);
    idle(2);
    out_ready = 1'b1;
    for (int k = 20; k < 26; k++) drive(1'b1, 32'(k) << SHIFT);
    check("drop_unchanged", {16'd0, drop_count}, 32'd2);
    idle(8);

    // Reset with 3 entries buffered
    out_ready = 1'b0;
    for (int k = 30; k < 33; k++) drive(1'b1, 32'(k) << SHIFT);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_drop", {16'd0, drop_count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    out_ready = 1'b1;
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d = 32'($signed(d) >>> 8);
      out_ready   = ($urandom_range(0, 3) != 0);
      clear_flags = ($urandom_range(0, 31) == 0);
      drive($urandom_range(0, 2) != 0, d);
    end
    clear_flags = 1'b0;
    out_ready = 1'b1;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
